// File: rtl/bht_pkg.sv
// ----------------------------------------------------------------------------
// bht_pkg
//   Shared definitions for the branch history table predictor:
//   - bht_state_e : table controller state (ST_INIT sweep-clear, ST_RUN)
//   - tag_w       : tag width for a given index width (PC bits above idx)
//   - ctr_weak_t  : weakly-taken counter value for a given counter width
//   - ctr_weak_nt : weakly-not-taken counter value for a given counter width
// ----------------------------------------------------------------------------
package bht_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bht_state_e;

   // PC[1:0] are ignored and PC[IDX_W+1:2] form the index; the rest is tag.
   function automatic int tag_w(input int idx_w);
      return 30 - idx_w;
   endfunction

   // 10..0 for CTR_W=2: MSB set, all lower bits clear.
   function automatic int ctr_weak_t(input int ctr_w);
      return 1 << (ctr_w - 1);
   endfunction

   // 01..1 for CTR_W=2: MSB clear, all lower bits set.
   function automatic int ctr_weak_nt(input int ctr_w);
      return (1 << (ctr_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/bht_predictor_if.sv
// ----------------------------------------------------------------------------
// bht_predictor_if
//   Lookup / update / status bundle between the pipeline and the predictor.
//   Handshake: lookup_valid and upd_valid are single-cycle qualifiers with
//   no backpressure. A lookup is answered combinationally in the same cycle;
//   an update is consumed at the next rising clk edge. While ready is low
//   (init sweep) lookups report a miss and updates are dropped.
//   modport master : pipeline side (drives lookup/update requests)
//   modport slave  : predictor side (drives predictions, ready, perf)
// ----------------------------------------------------------------------------
interface bht_predictor_if #(
   parameter int GHR_W  = 8,
   parameter int PERF_W = 32
);
   logic              lookup_valid;
   logic [31:0]       lookup_pc;
   logic              pred_hit;
   logic              pred_taken;
   logic [GHR_W-1:0]  pred_hist;
   logic              upd_valid;
   logic [31:0]       upd_pc;
   logic              upd_taken;
   logic              upd_pred_taken;
   logic [GHR_W-1:0]  upd_hist;
   logic              ready;
   logic [PERF_W-1:0] perf_lookups;
   logic [PERF_W-1:0] perf_mispred;

   modport master (
      output lookup_valid, lookup_pc,
      output upd_valid, upd_pc, upd_taken, upd_pred_taken, upd_hist,
      input  pred_hit, pred_taken, pred_hist, ready, perf_lookups, perf_mispred
   );

   modport slave (
      input  lookup_valid, lookup_pc,
      input  upd_valid, upd_pc, upd_taken, upd_pred_taken, upd_hist,
      output pred_hit, pred_taken, pred_hist, ready, perf_lookups, perf_mispred
   );
endinterface

// File: rtl/bht_sat_ctr.sv
// ----------------------------------------------------------------------------
// bht_sat_ctr
//   Combinational CTR_W-bit saturating increment/decrement.
//   ctr_i : current counter value
//   inc_i : 1 = count up (taken), 0 = count down (not taken)
//   ctr_o : next counter value, clamped to [0, 2**CTR_W-1]
// ----------------------------------------------------------------------------
module bht_sat_ctr #(
   parameter int CTR_W = 2
) (
   input  logic [CTR_W-1:0] ctr_i,
   input  logic             inc_i,
   output logic [CTR_W-1:0] ctr_o
);
   always_comb begin
      ctr_o = ctr_i;
      if (inc_i) begin
         if (ctr_i != '1) ctr_o = ctr_i + 1'b1;
      end else begin
         if (ctr_i != '0) ctr_o = ctr_i - 1'b1;
      end
   end
endmodule

// File: rtl/bht_predictor.sv
// ----------------------------------------------------------------------------
// bht_predictor
//   Tagged, direct-mapped branch history table with CTR_W-bit saturating
//   counters. Lookup is combinational on the fetch PC; resolved outcomes are
//   written back at the next clk edge. After reset a sweep clears one valid
//   bit per cycle; ready rises DEPTH cycles after reset deasserts.
//   Optional feature macro: BHT_GSHARE_EN (index XORed with global history).
// Ports
//   clk       : clock, rising edge
//   reset     : synchronous, active-high
//   bus       : bht_predictor_if.slave (lookup, update, ready, perf counters)
//   dbg_state : current controller state
// ----------------------------------------------------------------------------
module bht_predictor
   import bht_pkg::*;
#(
   parameter int IDX_W  = 10,
   parameter int CTR_W  = 2,
   parameter int GHR_W  = 8,
   parameter int PERF_W = 32
) (
   input  logic            clk,
   input  logic            reset,
   bht_predictor_if.slave  bus,
   output bht_state_e      dbg_state
);
   localparam int DEPTH = 2 ** IDX_W;
   localparam int TAG_W = tag_w(IDX_W);
   localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_t(CTR_W));
   localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_nt(CTR_W));

   // Storage: valid is a flop vector so the sweep can clear it; tag/ctr
   // arrays have no reset and a single write port (RAM-inferable).
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_mem [DEPTH];
   logic [CTR_W-1:0] ctr_mem [DEPTH];

   bht_state_e        state_q;
   logic [IDX_W-1:0]  sweep_q;
   logic              ready_q;
   logic [PERF_W-1:0] perf_lk_q, perf_lk_d;
   logic [PERF_W-1:0] perf_mp_q, perf_mp_d;

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             run;
   logic             lk_hit, up_hit, up_we;
   logic [CTR_W-1:0] ctr_step, up_wr_ctr;

   assign run    = (state_q == ST_RUN);
   assign lk_tag = bus.lookup_pc[31:IDX_W+2];
   assign up_tag = bus.upd_pc[31:IDX_W+2];

   logic unused_pc_lsb;
   assign unused_pc_lsb = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

`ifdef BHT_GSHARE_EN
   logic [GHR_W-1:0] ghr_q, ghr_d;

   // The update side uses the history captured at lookup time so that it
   // lands on the same entry the prediction came from.
   assign lk_idx        = bus.lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
   assign up_idx        = bus.upd_pc[IDX_W+1:2] ^ IDX_W'(bus.upd_hist);
   assign bus.pred_hist = ghr_q;

   always_comb begin
      ghr_d = ghr_q;
      if (up_we) ghr_d = {ghr_q[GHR_W-2:0], bus.upd_taken};
   end

   always_ff @(posedge clk) begin
      if (reset) ghr_q <= '0;
      else       ghr_q <= ghr_d;
   end
`else
   logic [GHR_W-1:0] unused_hist;
   assign unused_hist   = bus.upd_hist;
   assign lk_idx        = bus.lookup_pc[IDX_W+1:2];
   assign up_idx        = bus.upd_pc[IDX_W+1:2];
   assign bus.pred_hist = '0;
`endif

   // Lookup reads current contents only; a same-cycle update is not bypassed.
   assign lk_hit         = ready_q && valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
   assign bus.pred_hit   = lk_hit;
   assign bus.pred_taken = lk_hit ? ctr_mem[lk_idx][CTR_W-1] : 1'b1;

   // Update: train on hit, otherwise allocate with a weak counter.
   assign up_hit = valid_q[up_idx] && (tag_mem[up_idx] == up_tag);
   assign up_we  = run && !reset && bus.upd_valid;

   bht_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
      .ctr_i (ctr_mem[up_idx]),
      .inc_i (bus.upd_taken),
      .ctr_o (ctr_step)
   );

   assign up_wr_ctr = up_hit ? ctr_step : (bus.upd_taken ? CTR_WT : CTR_WNT);

   always_ff @(posedge clk) begin
      if (up_we) begin
         tag_mem[up_idx] <= up_tag;
         ctr_mem[up_idx] <= up_wr_ctr;
      end
   end

   always_comb begin
      valid_d = valid_q;
      if (state_q == ST_INIT) valid_d[sweep_q] = 1'b0;
      else if (up_we)         valid_d[up_idx]  = 1'b1;
   end

   // Cleared by the sweep, so no reset value is needed.
   always_ff @(posedge clk) begin
      valid_q <= valid_d;
   end

   always_comb begin
      perf_lk_d = perf_lk_q;
      perf_mp_d = perf_mp_q;
      if (run && bus.lookup_valid && (perf_lk_q != '1))
         perf_lk_d = perf_lk_q + 1'b1;
      if (run && bus.upd_valid && (bus.upd_taken != bus.upd_pred_taken) && (perf_mp_q != '1))
         perf_mp_d = perf_mp_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_lk_q <= '0;
         perf_mp_q <= '0;
      end else begin
         perf_lk_q <= perf_lk_d;
         perf_mp_q <= perf_mp_d;
      end
   end

   // Controller: sweep every index once, then run until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_INIT;
         sweep_q <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               sweep_q <= sweep_q + 1'b1;
               if (sweep_q == '1) begin
                  state_q <= ST_RUN;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_RUN;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready        = ready_q;
   assign bus.perf_lookups = perf_lk_q;
   assign bus.perf_mispred = perf_mp_q;
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_bht_predictor.sv
module tb_bht_predictor;
  import bht_pkg::*;

  logic       clk;
  logic       reset;
  bht_state_e dbg_state;
  int         n_tests;
  int         n_fail;
  int         exp_lookups;
  int         exp_mispred;

  bht_predictor_if #(.GHR_W(8), .PERF_W(32)) bus ();

  bht_predictor #(.IDX_W(10), .CTR_W(2), .GHR_W(8), .PERF_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic lookup(input logic [31:0] pc, input logic e_hit, input logic e_taken,
                        input string tag);
    bus.lookup_pc    = pc;
    bus.lookup_valid = 1'b1;
    #1;
    check({tag, "_hit"},   32'(bus.pred_hit),   32'(e_hit));
    check({tag, "_taken"}, 32'(bus.pred_taken), 32'(e_taken));
    @(negedge clk);
    bus.lookup_valid = 1'b0;
    exp_lookups++;
  endtask

  task automatic update(input logic [31:0] pc, input logic taken, input logic pred);
    bus.upd_pc         = pc;
    bus.upd_taken      = taken;
    bus.upd_pred_taken = pred;
    bus.upd_valid      = 1'b1;
    @(negedge clk);
    bus.upd_valid = 1'b0;
    if (taken != pred) exp_mispred++;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; exp_lookups = 0; exp_mispred = 0;
    reset = 1'b1;
    bus.lookup_valid = 1'b0; bus.lookup_pc = '0;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
    bus.upd_pred_taken = 1'b0; bus.upd_hist = '0;

    // 1: reset state, init sweep duration, lookups/updates during INIT
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",   32'(bus.ready), 32'd0);
    check("rst_state",   32'(dbg_state), 32'(ST_INIT));
    check("rst_perf_lk", bus.perf_lookups, 32'd0);
    check("rst_perf_mp", bus.perf_mispred, 32'd0);
`ifndef BHT_GSHARE_EN
    check("rst_hist",    32'(bus.pred_hist), 32'd0);
`endif
    reset = 1'b0;
    bus.lookup_pc = 32'h100; bus.lookup_valid = 1'b1;
    bus.upd_pc = 32'h400; bus.upd_taken = 1'b1; bus.upd_pred_taken = 1'b0; bus.upd_valid = 1'b1;
    repeat (1023) @(negedge clk);
    check("init_ready_1023", 32'(bus.ready), 32'd0);
    check("init_hit",        32'(bus.pred_hit), 32'd0);
    check("init_taken",      32'(bus.pred_taken), 32'd1);
    check("init_perf_lk",    bus.perf_lookups, 32'd0);
    @(negedge clk);
    bus.lookup_valid = 1'b0; bus.upd_valid = 1'b0;
    check("init_ready_1024", 32'(bus.ready), 32'd1);
    check("init_state_run",  32'(dbg_state), 32'(ST_RUN));
    check("init_perf_lk_fz", bus.perf_lookups, 32'd0);
    check("init_perf_mp_fz", bus.perf_mispred, 32'd0);
    lookup(32'h400, 1'b0, 1'b1, "init_upd_dropped");

    // 2: allocate not-taken, then train to weak taken
    update(32'h100, 1'b0, 1'b0);
    lookup(32'h100, 1'b1, 1'b0, "alloc_nt");
    update(32'h100, 1'b1, 1'b1);
    lookup(32'h100, 1'b1, 1'b1, "train_t");

    // 3: saturation at 11
    repeat (4) update(32'h200, 1'b1, 1'b1);
    lookup(32'h200, 1'b1, 1'b1, "sat_hi");
    update(32'h200, 1'b0, 1'b0);
    lookup(32'h200, 1'b1, 1'b1, "sat_dec1");
    update(32'h200, 1'b0, 1'b0);
    lookup(32'h200, 1'b1, 1'b0, "sat_dec2");

    // 4: alias on the same index replaces the entry
    update(32'h1100, 1'b1, 1'b1);
    lookup(32'h100,  1'b0, 1'b1, "alias_old");
    lookup(32'h1100, 1'b1, 1'b1, "alias_new");
    lookup(32'h103,  1'b0, 1'b1, "alias_old_lsb");

    // 5: same-cycle lookup and update, no bypass
    update(32'h300, 1'b0, 1'b0);
    bus.lookup_pc = 32'h300; bus.lookup_valid = 1'b1;
    bus.upd_pc = 32'h300; bus.upd_taken = 1'b1; bus.upd_pred_taken = 1'b1; bus.upd_valid = 1'b1;
    #1;
    check("same_cyc_hit",   32'(bus.pred_hit), 32'd1);
    check("same_cyc_taken", 32'(bus.pred_taken), 32'd0);
    @(negedge clk);
    bus.lookup_valid = 1'b0; bus.upd_valid = 1'b0;
    exp_lookups++;
    lookup(32'h300, 1'b1, 1'b1, "after_same_cyc");
    check("mispred_none", bus.perf_mispred, 32'd0);

    // 6: 10 updates with 3 direction mismatches (i = 2, 5, 7)
    for (int i = 0; i < 10; i++) begin
      logic t;
      t = i[0];
      update(32'h600 + 32'(4 * i), t, t ^ ((i == 2) || (i == 5) || (i == 7)));
    end
    check("mispred_3",     bus.perf_mispred, 32'd3);
    check("mispred_model", bus.perf_mispred, 32'(exp_mispred));
    lookup(32'h624, 1'b1, 1'b1, "perf_upd_entry");
    check("perf_lookups",  bus.perf_lookups, 32'(exp_lookups));

    // reset in the middle of INIT restarts the full sweep
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_lookups = 0;
    check("rst2_perf_lk", bus.perf_lookups, 32'd0);
    check("rst2_perf_mp", bus.perf_mispred, 32'd0);
    check("rst2_state",   32'(dbg_state), 32'(ST_INIT));
    repeat (500) @(negedge clk);
    check("mid_init_ready", 32'(bus.ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (1023) @(negedge clk);
    check("reinit_ready_1023", 32'(bus.ready), 32'd0);
    @(negedge clk);
    check("reinit_ready_1024", 32'(bus.ready), 32'd1);
    lookup(32'h200, 1'b0, 1'b1, "swept_clear");
    check("reinit_perf_lk", bus.perf_lookups, 32'(exp_lookups));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
